// File: rtl/switch_debounce_counter_display.sv
// Per-channel switch synchroniser, counter debouncer and mod-10 toggle counter,
// shown on active-low 7-segment digits as either switch state or toggle count.
module switch_debounce_counter_display #(
    parameter int NUM_CH          = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  KEY0,
    input  logic [NUM_CH-1:0]     SW,
    input  logic                  KEY1,
    input  logic                  MODE,
    output logic [NUM_CH-1:0]     LEDR,
    output logic [8*NUM_CH-1:0]   HEX
);

    localparam logic [CNT_W-1:0] DCNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] rise;
    logic [CNT_W-1:0]  dcnt  [NUM_CH];
    logic [3:0]        count [NUM_CH];
    logic              k1;
    logic              k2;
    logic              clr;

    // Segment bits g..a, active-low; out-of-range values show "E".
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b100_0000;
            4'd1:    seg7 = 7'b111_1001;
            4'd2:    seg7 = 7'b010_0100;
            4'd3:    seg7 = 7'b011_0000;
            4'd4:    seg7 = 7'b001_1001;
            4'd5:    seg7 = 7'b001_0010;
            4'd6:    seg7 = 7'b000_0010;
            4'd7:    seg7 = 7'b111_1000;
            4'd8:    seg7 = 7'b000_0000;
            4'd9:    seg7 = 7'b001_0000;
            default: seg7 = 7'b000_0110;
        endcase
    endfunction

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            s1 <= '0;
            s2 <= '0;
            k1 <= 1'b0;
            k2 <= 1'b0;
        end else begin
            s1 <= SW;
            s2 <= s1;
            k1 <= KEY1;
            k2 <= k1;
        end
    end

    assign clr = ~k2;

    // A rise is a 0->1 acceptance happening on this edge.
    always_comb begin
        rise = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rise[i] = s2[i] & ~stable[i] & (dcnt[i] == DCNT_MAX);
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            stable <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dcnt[i]  <= '0;
                count[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCNT_MAX) begin
                    stable[i] <= s2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end

                if (clr) begin
                    count[i] <= 4'd0;
                end else if (rise[i]) begin
                    count[i] <= (count[i] == 4'd9) ? 4'd0 : count[i] + 4'd1;
                end
            end
        end
    end

    // In count mode the DP lights while the switch is up.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            HEX <= {NUM_CH{8'hC0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (MODE) begin
                    HEX[8*i +: 8] <= {~stable[i], seg7(count[i])};
                end else begin
                    HEX[8*i +: 8] <= {1'b1, seg7({3'b000, stable[i]})};
                end
            end
        end
    end

    assign LEDR = stable;

endmodule

// File: tb/tb_switch_debounce_counter_display.sv
// Bench for switch_debounce_counter_display: directed scenarios followed by
// random switch/clear/mode activity, all compared against a sliding-window model.
module tb_switch_debounce_counter_display;

    localparam int NUM_CH = 6;
    localparam int DB     = 4;

    logic                clk = 1'b0;
    logic                key0;
    logic                key1;
    logic                mode;
    logic [NUM_CH-1:0]   sw;
    logic [NUM_CH-1:0]   ledr;
    logic [8*NUM_CH-1:0] hex;

    int checks = 0;
    int errors = 0;

    switch_debounce_counter_display #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .KEY0          (key0),
        .SW            (sw),
        .KEY1          (key1),
        .MODE          (mode),
        .LEDR          (ledr),
        .HEX           (hex)
    );

    always #5 clk = ~clk;

    // Reference model: input history per edge, accepted state, counts, digits.
    logic [NUM_CH-1:0] sw_q[$];
    logic              key_q[$];
    logic [NUM_CH-1:0] m_stable;
    int                m_count [NUM_CH];
    logic [7:0]        m_hex   [NUM_CH];
    logic [7:0]        digit_pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int                cnt_before [NUM_CH];

    function automatic logic [7:0] pat(input int d);
        if (d > 9) return 8'h86;
        return digit_pat[d];
    endfunction

    task automatic model_reset();
        sw_q.delete();
        key_q.delete();
        repeat (DB + 2) begin
            sw_q.push_back('0);
            key_q.push_back(1'b0);
        end
        m_stable = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_count[ch] = 0;
            m_hex[ch]   = 8'hC0;
        end
    endtask

    // A change is accepted when the last DB synchronised samples (two edges old)
    // all differ from the accepted state.
    task automatic model_edge();
        int   n;
        logic clr_m;
        bit   all_diff;
        bit   rise_m;
        n     = sw_q.size();
        clr_m = !key_q[n-2];
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mode) m_hex[ch] = pat(m_count[ch]) & (m_stable[ch] ? 8'h7F : 8'hFF);
            else      m_hex[ch] = pat(m_stable[ch] ? 1 : 0);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DB; k++) begin
                if (sw_q[n-1-k][ch] == m_stable[ch]) all_diff = 1'b0;
            end
            rise_m = all_diff && !m_stable[ch];
            if (all_diff) m_stable[ch] = !m_stable[ch];
            if (clr_m)       m_count[ch] = 0;
            else if (rise_m) m_count[ch] = (m_count[ch] + 1) % 10;
        end
        sw_q.push_back(sw);
        key_q.push_back(key1);
        void'(sw_q.pop_front());
        void'(key_q.pop_front());
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ledr"}, 64'(ledr), 64'(m_stable));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("%s_hex%0d", tag, ch), 64'(hex[8*ch +: 8]), 64'(m_hex[ch]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (key0) model_edge();
        #1;
        check_all("step");
    endtask

    initial begin
        key0 = 1'b1;
        key1 = 1'b1;
        mode = 1'b0;
        sw   = '0;
        model_reset();
        #2;
        key0 = 1'b0;
        #1;
        check("rst_ledr", 64'(ledr), 64'h0);
        check("rst_hex", 64'(hex), 64'h0000_C0C0_C0C0_C0C0);
        check_all("rst");
        repeat (2) step();
        key0 = 1'b1;
        step();

        // Clean rise on ch0, state mode.
        sw[0] = 1'b1;
        repeat (5) step();
        check("ch0_led_e5", 64'(ledr[0]), 64'h0);
        step();
        check("ch0_led_e6", 64'(ledr[0]), 64'h1);
        step();
        check("ch0_hex_e7", 64'(hex[7:0]), 64'hF9);

        // Bouncing ch1.
        sw[1] = 1'b1; step();
        sw[1] = 1'b0; step();
        sw[1] = 1'b1;
        repeat (5) step();
        check("ch1_led_e5", 64'(ledr[1]), 64'h0);
        step();
        check("ch1_led_e6", 64'(ledr[1]), 64'h1);
        mode = 1'b1;
        step();
        check("ch1_count_hex", 64'(hex[15:8]), 64'h79);

        // Eleven clean toggles on ch2 in count mode: wraps 9 -> 0.
        for (int i = 1; i <= 11; i++) begin
            sw[2] = 1'b1;
            repeat (7) step();
            check($sformatf("ch2_toggle%0d", i), 64'(hex[23:16]), 64'(digit_pat[i % 10] & 8'h7F));
            sw[2] = 1'b0;
            repeat (6) step();
        end

        // Ch3: one counted rise, then a clear landing on the acceptance edge.
        sw[3] = 1'b1; repeat (7) step();
        sw[3] = 1'b0; repeat (7) step();
        check("ch3_count1", 64'(hex[31:24]), 64'hF9);
        sw[3] = 1'b1;
        repeat (3) step();
        key1 = 1'b0; step();
        key1 = 1'b1;
        repeat (3) step();
        check("ch3_clr_wins", 64'(hex[31:24]), 64'h40);

        // Reset in the middle of a ch4 debounce.
        sw[4] = 1'b1;
        repeat (4) step();
        key0 = 1'b0;
        model_reset();
        #1;
        check("mid_rst_ledr", 64'(ledr), 64'h0);
        check("mid_rst_hex", 64'(hex), 64'h0000_C0C0_C0C0_C0C0);
        repeat (2) step();
        key0 = 1'b1;
        repeat (5) step();
        check("ch4_reaccept_e5", 64'(ledr[4]), 64'h0);
        step();
        check("ch4_reaccept_e6", 64'(ledr[4]), 64'h1);

        // All channels rise together, then a mode flip.
        sw = '0;
        repeat (7) step();
        for (int ch = 0; ch < NUM_CH; ch++) cnt_before[ch] = m_count[ch];
        sw = '1;
        repeat (7) step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("all_rise%0d", ch), 64'(hex[8*ch +: 8]),
                  64'(digit_pat[(cnt_before[ch] + 1) % 10] & 8'h7F));
        end
        mode = 1'b0;
        step();
        check("mode0_all", 64'(hex), 64'h0000_F9F9_F9F9_F9F9);
        mode = 1'b1;
        step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("kept%0d", ch), 64'(hex[8*ch +: 8]),
                  64'(digit_pat[(cnt_before[ch] + 1) % 10] & 8'h7F));
        end

        // Random switch activity with occasional clears and mode flips.
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, NUM_CH - 1);
                sw[b] = ~sw[b];
            end
            key1 = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
